cpu_bus_master: RTL and testbench
=================================

// Module: cpu_bus_master
// PURPOSE
//  Synthesizable CPU-side master for the C1 cache bus. Takes one request at a time (valid/ready), drives the
//  two-phase C1 address/command/data sequence into the cache, releases the shared cmd/data lines and returns
//  read data on a one-cycle response strobe. Sits between the ALU/sequencer and the Cache, replacing the
//  behavioural read/write tasks of the emulator.
// PARAMETERS
//  ADDR1_W     15  C1 address bus width (tag+set bits)
//  OFFSET_W    4   byte-offset width; full request address = ADDR1_W+OFFSET_W = 19
//  DATA1_W     16  C1 data bus width; one beat
//  TIMEOUT     1023  watchdog limit in cycles (used only with C1_TIMEOUT_EN)
// PORTS
//  clk          in   1        clock; all state on posedge
//  reset        in   1        asynchronous, active-high
//  req_valid    in   1        request present
//  req_ready    out  1        1 only in IDLE
//  req_cmd      in   3        C1_READ8/16/32, C1_INVALIDATE_LINE, C1_WRITE8/16/32
//  req_addr     in   19       byte address {tag,set,offset}
//  req_wdata    in   32       write data; low 8/16/32 bits used
//  rsp_valid    out  1        one-cycle pulse at completion
//  rsp_rdata    out  32       read data, zero-extended (0 for writes/invalidate)
//  rsp_err      out  1        valid with rsp_valid; timeout (macro only), else 0
//  busy_cycles  out  32       cycles spent outside IDLE since reset (saturating)
//  addr_cpu_w   out  ADDR1_W  C1 address bus
//  data_cpu_w   inout DATA1_W C1 data bus (tri-state)
//  cmd_cpu_w    inout 3       C1 command bus (tri-state)
// BEHAVIOUR
//  Reset (async): state IDLE, own bus, cmd_cpu_w=C1_NOP, data_cpu_w=Z, addr_cpu_w=0, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0, busy_cycles=0, req_ready=1. Reset mid-transaction aborts with no rsp.
//  Handshake: accept on posedge with req_valid&&req_ready; inputs latched, may change afterwards.
//   req_cmd=C1_NOP (or other non-command) accepted and dropped: no bus cycle, no rsp.
//  States: IDLE -> ADDR1 -> ADDR2 -> [WDATA2] -> TURN -> WAIT -> [RDATA2] -> DONE -> IDLE.
//   ADDR1: drive cmd=req_cmd, addr={tag,set}. ADDR2: addr=offset (zero-extended); writes drive data beat0
//   (bits 15:0, 8-bit zero-extended). WDATA2 (WRITE32 only): data beat1 = bits 31:16.
//   TURN: cmd and data driven Z (single turnaround cycle). WAIT: poll cmd_cpu_w each posedge;
//   on C1_RESPONSE reads latch beat0 -> rsp_rdata[15:0] (READ8 masks to [7:0]); READ32 goes to RDATA2,
//   latching next posedge beat -> rsp_rdata[31:16]; others go to DONE.
//   DONE: retake bus (drive C1_NOP), rsp_valid=1 for exactly this cycle, then IDLE.
//  Latency (cache answers first WAIT cycle): READ8/16/INV 5 cycles accept->rsp_valid; READ32 6; WRITE8/16 5;
//   WRITE32 6. Each WAIT cycle adds one.
//  Bus never driven by both sides: master outputs Z from TURN through last response beat.
//  rsp_rdata holds until next rsp_valid. busy_cycles increments every non-IDLE cycle, saturates at 2^32-1.
//  C1_RESPONSE seen in any state other than WAIT/RDATA2 is ignored.
// CONFIGURATION
//  C1_TIMEOUT_EN defined: counter cleared on entering WAIT; if TIMEOUT cycles pass with no C1_RESPONSE,
//   go to DONE with rsp_err=1, rsp_rdata=0; any late response while IDLE ignored.
//  Undefined: WAIT indefinitely; rsp_err tied 0; no counter logic.
// TESTING
//  Reset mid-WAIT: assert reset during WAIT -> next cycle cmd=C1_NOP, req_ready=1, no rsp_valid.
//  READ16 addr 19'h12345, cache responds 0xBEEF after 3 WAIT cycles -> addr 0x1234 then 0x5, rsp_rdata=0x0000BEEF, latency 7.
//  READ32, beats 0x1111 then 0x2222 -> rsp_rdata=0x22221111, one rsp_valid pulse.
//  WRITE32 data 0xCAFEBABE -> beat0 0xBABE at ADDR2, beat1 0xCAFE at WDATA2, bus Z at TURN, rsp_rdata=0.
//  Back-to-back READ8 with req_valid held -> second accepted cycle after DONE; busy_cycles=10.
//  C1_TIMEOUT_EN, TIMEOUT=8, no responder -> rsp_valid with rsp_err=1 eight cycles after WAIT entry.

Source files
------------

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: CPU-side master for the two-phase C1 cache bus.
// Accepts one request at a time and runs the address/command/data phases on the shared C1 bus.
// It turns the bus around for the cache's response and returns read data on a one-cycle strobe.
// Optional watchdog: define C1_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
module cpu_bus_master #(
    parameter int unsigned ADDR1_W  = 15,
    parameter int unsigned OFFSET_W = 4,
    parameter int unsigned DATA1_W  = 16,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [2:0]                   req_cmd,
    input  logic [ADDR1_W+OFFSET_W-1:0]  req_addr,
    input  logic [31:0]                  req_wdata,
    output logic                         rsp_valid,
    output logic [31:0]                  rsp_rdata,
    output logic                         rsp_err,
    output logic [31:0]                  busy_cycles,
    output logic [ADDR1_W-1:0]           addr_cpu_w,
    inout  wire  [DATA1_W-1:0]           data_cpu_w,
    inout  wire  [2:0]                   cmd_cpu_w
);

    // C1 command encodings; RESPONSE shares a code with WRITE32 but only travels cache->CPU
    localparam logic [2:0] C1_NOP             = 3'd0;
    localparam logic [2:0] C1_READ8           = 3'd1;
    localparam logic [2:0] C1_READ16          = 3'd2;
    localparam logic [2:0] C1_READ32          = 3'd3;
    localparam logic [2:0] C1_INVALIDATE_LINE = 3'd4;
    localparam logic [2:0] C1_WRITE8          = 3'd5;
    localparam logic [2:0] C1_WRITE32         = 3'd7;
    localparam logic [2:0] C1_RESPONSE        = 3'd7;

    typedef enum logic [2:0] {
        StIdle, StAddr1, StAddr2, StWdata2, StTurn, StWait, StRdata2, StDone
    } state_e;

    state_e               state_q;
    logic [2:0]           cmd_q;
    logic [31:0]          wdata_q;
    logic [OFFSET_W-1:0]  offset_q;
    logic [DATA1_W-1:0]   beat0_q;
    logic [DATA1_W-1:0]   data_out_q;
    logic                 data_oe_q;
    logic [2:0]           cmd_out_q;
    logic                 cmd_oe_q;
    logic                 is_write;
    logic                 rsp_seen;

    assign is_write  = (cmd_q >= C1_WRITE8);
    assign rsp_seen  = (cmd_cpu_w == C1_RESPONSE);
    assign req_ready = (state_q == StIdle);

    // Shared bus drivers: released whenever the cache owns the lines
    assign data_cpu_w = data_oe_q ? data_out_q : {DATA1_W{1'bz}};
    assign cmd_cpu_w  = cmd_oe_q ? cmd_out_q : 3'bzzz;

`ifdef C1_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q;
    logic          err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Transaction FSM with all bus and response outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_q       <= C1_NOP;
            wdata_q     <= '0;
            offset_q    <= '0;
            beat0_q     <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            cmd_out_q   <= C1_NOP;
            cmd_oe_q    <= 1'b1;
            addr_cpu_w  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            busy_cycles <= '0;
`ifdef C1_TIMEOUT_EN
            timer_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            if (state_q != StIdle && busy_cycles != '1) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
            unique case (state_q)
                StIdle: begin
                    // NOP requests are handshaken but never reach the bus
                    if (req_valid && req_cmd != C1_NOP) begin
                        cmd_q      <= req_cmd;
                        wdata_q    <= req_wdata;
                        offset_q   <= req_addr[OFFSET_W-1:0];
                        addr_cpu_w <= req_addr[ADDR1_W+OFFSET_W-1:OFFSET_W];
                        cmd_out_q  <= req_cmd;
                        cmd_oe_q   <= 1'b1;
                        state_q    <= StAddr1;
                    end
                end
                StAddr1: begin
                    addr_cpu_w <= ADDR1_W'(offset_q);
                    if (is_write) begin
                        data_oe_q  <= 1'b1;
                        data_out_q <= (cmd_q == C1_WRITE8) ? DATA1_W'(wdata_q[7:0])
                                                           : wdata_q[DATA1_W-1:0];
                    end
                    state_q <= StAddr2;
                end
                StAddr2: begin
                    if (cmd_q == C1_WRITE32) begin
                        data_out_q <= wdata_q[2*DATA1_W-1:DATA1_W];
                        state_q    <= StWdata2;
                    end else begin
                        cmd_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        state_q   <= StTurn;
                    end
                end
                StWdata2: begin
                    cmd_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state_q   <= StTurn;
                end
                StTurn: begin
`ifdef C1_TIMEOUT_EN
                    timer_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (rsp_seen) begin
                        if (cmd_q == C1_READ32) begin
                            beat0_q <= data_cpu_w;
                            state_q <= StRdata2;
                        end else begin
                            if (cmd_q == C1_READ8) begin
                                rsp_rdata <= 32'(data_cpu_w[7:0]);
                            end else if (cmd_q == C1_READ16) begin
                                rsp_rdata <= 32'(data_cpu_w);
                            end else begin
                                rsp_rdata <= '0;
                            end
                            cmd_oe_q  <= 1'b1;
                            cmd_out_q <= C1_NOP;
                            rsp_valid <= 1'b1;
`ifdef C1_TIMEOUT_EN
                            err_q     <= 1'b0;
`endif
                            state_q   <= StDone;
                        end
`ifdef C1_TIMEOUT_EN
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        rsp_rdata <= '0;
                        cmd_oe_q  <= 1'b1;
                        cmd_out_q <= C1_NOP;
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        timer_q <= timer_q + TW'(1);
`endif
                    end
                end
                StRdata2: begin
                    // Second beat is taken unconditionally on the edge after the first
                    rsp_rdata <= 32'({data_cpu_w, beat0_q});
                    cmd_oe_q  <= 1'b1;
                    cmd_out_q <= C1_NOP;
                    rsp_valid <= 1'b1;
`ifdef C1_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                    state_q   <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: randomized bench with a transaction-level reference model and a cache responder.
module tb_cpu_bus_master;

    localparam logic [2:0] NOP = 3'd0, R8 = 3'd1, R16 = 3'd2, R32 = 3'd3, INV = 3'd4;
    localparam logic [2:0] W8 = 3'd5, W16 = 3'd6, W32 = 3'd7, RESP = 3'd7;
`ifdef C1_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1023;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] busy_cycles;
    logic [14:0] addr_bus;
    wire  [15:0] data_bus;
    wire  [2:0]  cmd_bus;

    logic        tb_cmd_oe = 1'b0;
    logic        tb_data_oe = 1'b0;
    logic [2:0]  tb_cmd = 3'd0;
    logic [15:0] tb_data = 16'd0;

    assign cmd_bus  = tb_cmd_oe ? tb_cmd : 3'bzzz;
    assign data_bus = tb_data_oe ? tb_data : 16'hzzzz;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] busy_exp;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    cpu_bus_master #(
        .ADDR1_W (15),
        .OFFSET_W(4),
        .DATA1_W (16),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy_cycles(busy_cycles),
        .addr_cpu_w (addr_bus),
        .data_cpu_w (data_bus),
        .cmd_cpu_w  (cmd_bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_cmd    = NOP;
        req_addr   = '0;
        req_wdata  = '0;
        tb_cmd_oe  = 1'b0;
        tb_data_oe = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd", 32'(cmd_bus), 32'(NOP));
        check_eq("rst_addr", 32'(addr_bus), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_err", 32'(rsp_err), 32'd0);
        check_eq("rst_busy", busy_cycles, 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        reset    = 1'b0;
        busy_exp = '0;
        last_rd  = '0;
    endtask

    // One request end to end; wait_n = WAIT cycle carrying the response, 0 = cache never answers
    task automatic run_txn(input logic [2:0] cmd, input logic [18:0] addr, input logic [31:0] wd,
                           input int wait_n, input logic [15:0] b0, input logic [15:0] b1,
                           input bit hold);
        int          ws;
        int          lat;
        int          resp_k;
        bit          seen;
        bit          wr;
        logic [31:0] exp_rd;
        logic [15:0] exp_beat0;
        wr        = (cmd >= W8);
        ws        = (cmd == W32) ? 5 : 4;
        lat       = (wait_n == 0) ? ws + TO : ws + wait_n + ((cmd == R32) ? 1 : 0);
        resp_k    = ws + wait_n - 1;
        exp_beat0 = (cmd == W8) ? {8'h00, wd[7:0]} : wd[15:0];
        if (wait_n == 0)     exp_rd = 32'd0;
        else if (cmd == R8)  exp_rd = {24'd0, b0[7:0]};
        else if (cmd == R16) exp_rd = {16'd0, b0};
        else if (cmd == R32) exp_rd = {b1, b0};
        else                 exp_rd = 32'd0;

        @(negedge clk);
        check_eq("ready_idle", 32'(req_ready), 32'd1);
        check_eq("rsp_single_pulse", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        if (!hold) begin
            req_valid = 1'b0;
            req_cmd   = 3'($urandom);
            req_addr  = 19'($urandom);
            req_wdata = $urandom;
        end
        seen = 1'b0;
        for (int k = 1; k <= lat + 2 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check_eq("addr1_cmd", 32'(cmd_bus), 32'(cmd));
                check_eq("addr1_tagset", 32'(addr_bus), 32'(addr[18:4]));
                check_eq("rdata_hold", rsp_rdata, last_rd);
                check_eq("ready_busy", 32'(req_ready), 32'd0);
            end
            if (k == 2) begin
                check_eq("addr2_offset", 32'(addr_bus), 32'(addr[3:0]));
                if (wr) check_eq("wdata_beat0", 32'(data_bus), 32'(exp_beat0));
            end
            if (k == 3 && cmd == W32) check_eq("wdata_beat1", 32'(data_bus), 32'(wd[31:16]));
            if (k >= ws && k < lat) begin
                tb_cmd_oe  = 1'b1;
                tb_data_oe = 1'b1;
                tb_cmd     = NOP;
                tb_data    = 16'($urandom);
                if (wait_n != 0 && k == resp_k) begin
                    tb_cmd  = RESP;
                    tb_data = b0;
                end
                if (wait_n != 0 && cmd == R32 && k == resp_k + 1) tb_data = b1;
                #1;
                check_eq("wait_cmd_released", 32'(cmd_bus), 32'(tb_cmd));
                check_eq("wait_data_released", 32'(data_bus), 32'(tb_data));
            end
            if (rsp_valid) begin
                seen = 1'b1;
                check_eq("latency", 32'(k), 32'(lat));
                check_eq("rdata", rsp_rdata, exp_rd);
                check_eq("err", 32'(rsp_err), 32'(wait_n == 0));
                check_eq("busy_at_rsp", busy_cycles, busy_exp + 32'(lat) - 32'd1);
                check_eq("done_cmd_nop", 32'(cmd_bus), 32'(NOP));
            end
            @(posedge clk);
            #1;
            tb_cmd_oe  = 1'b0;
            tb_data_oe = 1'b0;
        end
        check_eq("rsp_seen", 32'(seen), 32'd1);
        busy_exp = busy_exp + 32'(lat);
        last_rd  = exp_rd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c;
        do_reset();

        run_txn(R16, 19'h12345, 32'd0, 3, 16'hBEEF, 16'h0000, 1'b0);
        run_txn(R32, 19'h00ABC, 32'd0, 1, 16'h1111, 16'h2222, 1'b0);
        run_txn(W32, 19'h7FFFF, 32'hCAFEBABE, 1, 16'h0000, 16'h0000, 1'b0);
        run_txn(W8, 19'h00010, 32'h123456A5, 2, 16'hFFFF, 16'h0000, 1'b0);

        // NOP request is accepted and dropped
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = NOP;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("nop_ready", 32'(req_ready), 32'd1);
            check_eq("nop_no_rsp", 32'(rsp_valid), 32'd0);
            check_eq("nop_busy", busy_cycles, busy_exp);
        end

        // Back-to-back READ8 with req_valid held high
        do_reset();
        run_txn(R8, 19'h01234, 32'd0, 1, 16'hA55A, 16'h0000, 1'b1);
        run_txn(R8, 19'h04321, 32'd0, 1, 16'h3C7E, 16'h0000, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("b2b_busy", busy_cycles, busy_exp);
        check_eq("b2b_ready", 32'(req_ready), 32'd1);

        // Reset asserted in the middle of WAIT aborts without a response
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = R16;
        req_addr  = 19'($urandom);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst_cmd_nop", 32'(cmd_bus), 32'(NOP));
        check_eq("midrst_ready", 32'(req_ready), 32'd1);
        check_eq("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        busy_exp = '0;
        last_rd  = '0;
        repeat (3) begin
            @(negedge clk);
            check_eq("postrst_no_rsp", 32'(rsp_valid), 32'd0);
            check_eq("postrst_busy", busy_cycles, 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            c = 3'($urandom_range(1, 7));
            run_txn(c, 19'($urandom), $urandom, int'($urandom_range(1, 4)),
                    16'($urandom), 16'($urandom), 1'b0);
        end

`ifdef C1_TIMEOUT_EN
        run_txn(R16, 19'($urandom), 32'd0, 0, 16'd0, 16'd0, 1'b0);
        // A late response while idle must be ignored
        @(negedge clk);
        tb_cmd_oe  = 1'b1;
        tb_data_oe = 1'b1;
        tb_cmd     = RESP;
        tb_data    = 16'h5A5A;
        @(posedge clk);
        #1;
        tb_cmd_oe  = 1'b0;
        tb_data_oe = 1'b0;
        @(negedge clk);
        check_eq("late_rsp_ignored", 32'(rsp_valid), 32'd0);
        check_eq("late_rsp_ready", 32'(req_ready), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
